// File: rtl/fill_pkg.sv
// Shared encodings for the bottling-line fill sequencer: state and error codes, BCD digit width.
package fill_pkg;
  localparam int BCD_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_INDEX = 3'd2,
    S_DONE  = 3'd3,
    S_ESTOP = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_HOPPER = 2'd1,
    ERR_JAM    = 2'd2,
    ERR_ESTOP  = 2'd3
  } err_e;
endpackage

// File: rtl/bcd_up_counter.sv
// Multi-digit BCD up counter; nxt_o is the value one increment ahead, used for target compares.
module bcd_up_counter
  import fill_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                      clk_1khz,
  input  logic                      switch_clr,
  input  logic                      inc_i,
  input  logic                      clr_i,
  output logic [DIGITS*BCD_W-1:0]   value_o,
  output logic [DIGITS*BCD_W-1:0]   nxt_o
);
  logic [DIGITS*BCD_W-1:0] value_q;
  logic [DIGITS-1:0]       cin;

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    logic [BCD_W-1:0] dig;
    assign dig = value_q[d*BCD_W +: BCD_W];
    if (d == 0) begin : g_lsd
      assign cin[d] = 1'b1;
    end else begin : g_upper
      // carry ripples only while every lower digit sits at 9
      assign cin[d] = cin[d-1] & (value_q[(d-1)*BCD_W +: BCD_W] == 4'd9);
    end
    assign nxt_o[d*BCD_W +: BCD_W] = !cin[d]      ? dig :
                                     (dig == 4'd9) ? 4'd0 : dig + 4'd1;
  end

  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr)  value_q <= '0;
    else if (clr_i)   value_q <= '0;
    else if (inc_i)   value_q <= nxt_o;
  end

  assign value_o = value_q;
endmodule

// File: rtl/fill_sequencer.sv
// Bottling-line run-time controller: hopper gate, conveyor indexing, BCD pill/bottle counts and faults.
module fill_sequencer
  import fill_pkg::*;
#(
  parameter int PILL_TIMEOUT_MS = 3000,
  parameter int INDEX_MS        = 500,
  parameter int TMR_W           = 12
) (
  input  logic        clk_1khz,
  input  logic        switch_clr,
  input  logic        start,
  input  logic        resume,
  input  logic        clear,
  input  logic [11:0] tgt_pills,
  input  logic [7:0]  tgt_bottles,
  input  logic        pill_pulse,
  input  logic        estop,
  input  logic        conveyor_stall,
  output logic        hopper_open,
  output logic        conveyor_run,
  output logic [11:0] now_pills,
  output logic [7:0]  now_bottles,
  output logic        bottle_done,
  output logic [2:0]  state_o,
  output logic [1:0]  err_code
);
  localparam logic [TMR_W-1:0] PILL_LAST  = TMR_W'(PILL_TIMEOUT_MS - 1);
  localparam logic [TMR_W-1:0] INDEX_LAST = TMR_W'(INDEX_MS - 1);

  state_e            state_q, state_d, saved_q, saved_d;
  err_e              err_q, err_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              pill_prev_q;
  logic              hopper_q, conv_q, done_q, done_d;
  logic              p_inc, p_clr, b_inc, b_clr;
  logic [11:0]       p_nxt;
  logic [7:0]        b_nxt;
  logic              pill_edge;

  assign pill_edge = pill_pulse & ~pill_prev_q;

  bcd_up_counter #(.DIGITS(3)) u_pills (
    .clk_1khz   (clk_1khz),
    .switch_clr (switch_clr),
    .inc_i      (p_inc),
    .clr_i      (p_clr),
    .value_o    (now_pills),
    .nxt_o      (p_nxt)
  );

  bcd_up_counter #(.DIGITS(2)) u_bottles (
    .clk_1khz   (clk_1khz),
    .switch_clr (switch_clr),
    .inc_i      (b_inc),
    .clr_i      (b_clr),
    .value_o    (now_bottles),
    .nxt_o      (b_nxt)
  );

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    err_d   = err_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    p_inc   = 1'b0;
    p_clr   = 1'b0;
    b_inc   = 1'b0;
    b_clr   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!estop && (clear || start)) begin
          p_clr   = 1'b1;
          b_clr   = 1'b1;
          timer_d = '0;
          if (!clear && tgt_pills != 12'h000 && tgt_bottles != 8'h00) state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (estop) begin
          state_d = S_ESTOP;
          saved_d = S_FILL;
          err_d   = ERR_ESTOP;
        end else if (clear) begin
          state_d = S_IDLE;
          err_d   = ERR_NONE;
          timer_d = '0;
          p_clr   = 1'b1;
          b_clr   = 1'b1;
        end else if (pill_edge) begin
          // an edge on the timeout cycle wins over the hopper-empty fault
          p_inc   = 1'b1;
          timer_d = '0;
          if (p_nxt == tgt_pills) begin
            p_clr   = 1'b1;
            b_inc   = 1'b1;
            done_d  = 1'b1;
            state_d = (b_nxt == tgt_bottles) ? S_DONE : S_INDEX;
          end
        end else if (timer_q == PILL_LAST) begin
          state_d = S_FAULT;
          err_d   = ERR_HOPPER;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_INDEX: begin
        if (estop) begin
          state_d = S_ESTOP;
          saved_d = S_INDEX;
          err_d   = ERR_ESTOP;
        end else if (clear) begin
          state_d = S_IDLE;
          err_d   = ERR_NONE;
          timer_d = '0;
          p_clr   = 1'b1;
          b_clr   = 1'b1;
        end else if (conveyor_stall) begin
          state_d = S_FAULT;
          err_d   = ERR_JAM;
        end else if (timer_q == INDEX_LAST) begin
          state_d = S_FILL;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!estop && (start || clear)) begin
          state_d = S_IDLE;
          timer_d = '0;
          p_clr   = 1'b1;
          b_clr   = 1'b1;
        end
      end
      S_ESTOP: begin
        if (!estop && clear) begin
          state_d = S_IDLE;
          err_d   = ERR_NONE;
          timer_d = '0;
          p_clr   = 1'b1;
          b_clr   = 1'b1;
        end else if (!estop && resume) begin
          state_d = saved_q;
          err_d   = ERR_NONE;
          timer_d = '0;
        end
      end
      S_FAULT: begin
        if (clear) begin
          state_d = S_IDLE;
          err_d   = ERR_NONE;
          timer_d = '0;
          p_clr   = 1'b1;
          b_clr   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // actuators decode state_d so they switch on the same edge as the state
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      state_q     <= S_IDLE;
      saved_q     <= S_IDLE;
      err_q       <= ERR_NONE;
      timer_q     <= '0;
      pill_prev_q <= 1'b0;
      hopper_q    <= 1'b0;
      conv_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
      pill_prev_q <= pill_pulse;
      hopper_q    <= (state_d == S_FILL);
      conv_q      <= (state_d == S_INDEX);
      done_q      <= done_d;
    end
  end

  assign hopper_open  = hopper_q;
  assign conveyor_run = conv_q;
  assign bottle_done  = done_q;
  assign state_o      = state_q;
  assign err_code     = err_q;
endmodule

// File: tb/tb_fill_sequencer.sv
// Scoreboard bench for fill_sequencer: stimulus queues expected events, a negedge monitor pops and compares.
module tb_fill_sequencer;
  localparam logic [2:0] IDLE = 3'd0, FILL = 3'd1, INDEX = 3'd2, DONE = 3'd3,
                         ESTOP = 3'd4, FAULT = 3'd5;

  logic        clk, switch_clr, start, resume, clear, pill_pulse, estop, conveyor_stall;
  logic [11:0] tgt_pills, now_pills;
  logic [7:0]  tgt_bottles, now_bottles;
  logic        hopper_open, conveyor_run, bottle_done;
  logic [2:0]  state_o;
  logic [1:0]  err_code;

  int total = 0;
  int bad   = 0;
  logic [6:0]  st_q[$];   // {state, err, hopper, conveyor} at each state change
  logic [11:0] pl_q[$];   // now_pills at each change
  logic [7:0]  bd_q[$];   // now_bottles at each bottle_done pulse
  int          last_run = 0;
  logic [11:0] exp_p [11];

  fill_sequencer #(.PILL_TIMEOUT_MS(50), .INDEX_MS(10), .TMR_W(12)) dut (
    .clk_1khz       (clk),
    .switch_clr     (switch_clr),
    .start          (start),
    .resume         (resume),
    .clear          (clear),
    .tgt_pills      (tgt_pills),
    .tgt_bottles    (tgt_bottles),
    .pill_pulse     (pill_pulse),
    .estop          (estop),
    .conveyor_stall (conveyor_stall),
    .hopper_open    (hopper_open),
    .conveyor_run   (conveyor_run),
    .now_pills      (now_pills),
    .now_bottles    (now_bottles),
    .bottle_done    (bottle_done),
    .state_o        (state_o),
    .err_code       (err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic unexp(input string nm, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: unexpected change to %0h at %0t", nm, act, $time);
  endtask

  // monitor: pops an expectation whenever the DUT presents a change or a pulse
  initial begin
    logic [2:0]  last_st;
    logic [11:0] last_pl;
    int          run;
    last_st = '0;
    last_pl = '0;
    run     = 0;
    forever begin
      @(negedge clk);
      if (state_o !== last_st) begin
        if (st_q.size() == 0) unexp("state", 32'(state_o));
        else chk("state_evt", 32'({state_o, err_code, hopper_open, conveyor_run}), 32'(st_q.pop_front()));
        last_st = state_o;
      end
      if (now_pills !== last_pl) begin
        if (pl_q.size() == 0) unexp("pills", 32'(now_pills));
        else chk("pills_evt", 32'(now_pills), 32'(pl_q.pop_front()));
        last_pl = now_pills;
      end
      if (bottle_done === 1'b1) begin
        if (bd_q.size() == 0) unexp("bottle_done", 32'(now_bottles));
        else chk("bottle_evt", 32'(now_bottles), 32'(bd_q.pop_front()));
      end
      if (conveyor_run === 1'b1) run++;
      else if (run != 0) begin
        last_run = run;
        run = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pill();
    pill_pulse = 1'b1;
    cyc(1);
    pill_pulse = 1'b0;
    cyc(4);
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, input string nm);
    int n = 0;
    while (state_o !== s && n < lim) begin
      cyc(1);
      n++;
    end
    chk(nm, 32'(state_o), 32'(s));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    cyc(1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_p = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006,
              12'h007, 12'h008, 12'h009, 12'h010, 12'h011};
    switch_clr = 1'b0; start = 1'b0; resume = 1'b0; clear = 1'b0;
    pill_pulse = 1'b0; estop = 1'b0; conveyor_stall = 1'b0;
    tgt_pills = 12'h000; tgt_bottles = 8'h00;
    cyc(2);
    chk("rst_state", 32'(state_o), 32'(IDLE));
    chk("rst_act", 32'({hopper_open, conveyor_run, bottle_done}), 0);
    chk("rst_counts", 32'({now_pills, now_bottles}), 0);
    chk("rst_err", 32'(err_code), 0);
    switch_clr = 1'b1;
    cyc(1);

    // two bottles of three pills
    tgt_pills = 12'h003; tgt_bottles = 8'h02;
    st_q.push_back({FILL, 2'd0, 2'b10});
    st_q.push_back({INDEX, 2'd0, 2'b01});
    st_q.push_back({FILL, 2'd0, 2'b10});
    st_q.push_back({DONE, 2'd0, 2'b00});
    st_q.push_back({IDLE, 2'd0, 2'b00});
    pl_q.push_back(12'h001); pl_q.push_back(12'h002); pl_q.push_back(12'h000);
    pl_q.push_back(12'h001); pl_q.push_back(12'h002); pl_q.push_back(12'h000);
    bd_q.push_back(8'h01); bd_q.push_back(8'h02);
    pulse_start();
    repeat (3) pill();
    wait_state(FILL, 30, "t1_back_to_fill");
    cyc(1);
    chk("t1_index_len", 32'(last_run), 10);
    repeat (3) pill();
    cyc(2);
    chk("t1_done_state", 32'(state_o), 32'(DONE));
    chk("t1_done_counts", 32'({now_pills, now_bottles}), 32'({12'h000, 8'h02}));
    chk("t1_done_hopper", 32'(hopper_open), 0);
    pulse_start();
    cyc(1);
    chk("t1_idle_bottles", 32'(now_bottles), 0);

    // hopper-empty timeout after 11 of 12 pills, through the 009->010 carry
    tgt_pills = 12'h012; tgt_bottles = 8'h02;
    st_q.push_back({FILL, 2'd0, 2'b10});
    st_q.push_back({FAULT, 2'd1, 2'b00});
    st_q.push_back({IDLE, 2'd0, 2'b00});
    for (int i = 0; i < 11; i++) pl_q.push_back(exp_p[i]);
    pl_q.push_back(12'h000);
    pulse_start();
    repeat (11) pill();
    cyc(45);
    chk("t2_before_timeout", 32'(state_o), 32'(FILL));
    cyc(1);
    chk("t2_fault_state", 32'(state_o), 32'(FAULT));
    chk("t2_fault_err", 32'(err_code), 1);
    chk("t2_pills_held", 32'(now_pills), 32'(12'h011));
    pulse_start();
    cyc(1);
    chk("t2_start_ignored", 32'(state_o), 32'(FAULT));
    pulse_clear();
    chk("t2_clear_counts", 32'({now_pills, now_bottles, err_code}), 0);

    // estop during INDEX at timer=4, then resume
    tgt_pills = 12'h002; tgt_bottles = 8'h03;
    st_q.push_back({FILL, 2'd0, 2'b10});
    st_q.push_back({INDEX, 2'd0, 2'b01});
    st_q.push_back({ESTOP, 2'd3, 2'b00});
    st_q.push_back({INDEX, 2'd0, 2'b01});
    st_q.push_back({FILL, 2'd0, 2'b10});
    st_q.push_back({IDLE, 2'd0, 2'b00});
    pl_q.push_back(12'h001); pl_q.push_back(12'h000);
    bd_q.push_back(8'h01);
    pulse_start();
    repeat (2) pill();
    estop = 1'b1;
    cyc(1);
    chk("t3_estop_conv", 32'(conveyor_run), 0);
    chk("t3_estop_err", 32'(err_code), 3);
    cyc(3);
    chk("t3_estop_frozen", 32'({now_pills, now_bottles}), 32'({12'h000, 8'h01}));
    estop = 1'b0;
    resume = 1'b1;
    cyc(1);
    resume = 1'b0;
    wait_state(FILL, 30, "t3_resume_to_fill");
    cyc(1);
    chk("t3_resume_len", 32'(last_run), 10);
    chk("t3_counts", 32'({now_pills, now_bottles}), 32'({12'h000, 8'h01}));
    pulse_clear();

    // conveyor jam
    tgt_pills = 12'h001; tgt_bottles = 8'h02;
    st_q.push_back({FILL, 2'd0, 2'b10});
    st_q.push_back({INDEX, 2'd0, 2'b01});
    st_q.push_back({FAULT, 2'd2, 2'b00});
    st_q.push_back({IDLE, 2'd0, 2'b00});
    bd_q.push_back(8'h01);
    pulse_start();
    pill();
    conveyor_stall = 1'b1;
    cyc(1);
    conveyor_stall = 1'b0;
    chk("t4_jam_err", 32'(err_code), 2);
    start = 1'b1;
    cyc(2);
    start = 1'b0;
    chk("t4_start_ignored", 32'(state_o), 32'(FAULT));
    pulse_clear();
    chk("t4_clear", 32'({err_code, now_bottles}), 0);

    // zero targets and clear+start collision keep the block idle
    tgt_pills = 12'h000; tgt_bottles = 8'h02;
    pulse_start();
    cyc(1);
    chk("t5_zero_pills", 32'({state_o, hopper_open, conveyor_run}), 32'({IDLE, 2'b00}));
    tgt_pills = 12'h001; tgt_bottles = 8'h00;
    pulse_start();
    cyc(1);
    chk("t5_zero_bottles", 32'({state_o, hopper_open, conveyor_run}), 32'({IDLE, 2'b00}));
    tgt_bottles = 8'h02;
    clear = 1'b1; start = 1'b1;
    cyc(1);
    clear = 1'b0; start = 1'b0;
    cyc(1);
    chk("t5_clear_wins", 32'(state_o), 32'(IDLE));

    // ten pills through the carry, then async reset mid-FILL
    tgt_pills = 12'h010; tgt_bottles = 8'h02;
    st_q.push_back({FILL, 2'd0, 2'b10});
    st_q.push_back({INDEX, 2'd0, 2'b01});
    st_q.push_back({FILL, 2'd0, 2'b10});
    st_q.push_back({IDLE, 2'd0, 2'b00});
    for (int i = 0; i < 9; i++) pl_q.push_back(exp_p[i]);
    pl_q.push_back(12'h000);
    pl_q.push_back(12'h001); pl_q.push_back(12'h002); pl_q.push_back(12'h003);
    pl_q.push_back(12'h000);
    bd_q.push_back(8'h01);
    pulse_start();
    repeat (10) pill();
    wait_state(FILL, 30, "t6_back_to_fill");
    repeat (3) pill();
    #2;
    switch_clr = 1'b0;
    #1;
    chk("t6_rst_state", 32'(state_o), 32'(IDLE));
    chk("t6_rst_act", 32'({hopper_open, conveyor_run, bottle_done}), 0);
    chk("t6_rst_counts", 32'({now_pills, now_bottles, err_code}), 0);
    cyc(2);
    switch_clr = 1'b1;
    cyc(3);

    chk("st_q_drained", 32'(st_q.size()), 0);
    chk("pl_q_drained", 32'(pl_q.size()), 0);
    chk("bd_q_drained", 32'(bd_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
